sysbus_mem_responder: RTL
=========================

SYSBUS_MEM_RESPONDER -- requirements
Module: sysbus_mem_responder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 - MEM_LINES, 256, number of 64-byte lines in the internal store (power of two).
 - LATENCY, 4, idle cycles between reqack and the first read response beat (>=1).
REQ-002 Ports (name, direction, width, meaning), one per line:
 - clk  in  1  single clock; all state changes on the rising edge.
 - reset  in  1  asynchronous, active-high reset.
 - reqcyc  in  1  initiator request valid, held high until reqack.
 - req  in  64  request address cycle, then write data beats.
 - reqtag  in  13  [12]=1 READ / 0 WRITE, [11:8] type (4'b0001 MEMORY), [7:0] id.
 - reqack  out  1  one-cycle request acceptance pulse.
 - respcyc  out  1  response beat valid.
 - resp  out  64  response data beat.
 - resptag  out  13  copy of the accepted reqtag, valid with respcyc.
 - respack  in  1  initiator accepts the current beat while respcyc is high.
REQ-003 The reset is asynchronous and active-high; the block uses one clock.

Function
REQ-004 The state machine SHALL have states IDLE, WDATA, WAIT, RESP.
REQ-005 In IDLE with reqcyc=1, the block SHALL do all of the following at the next edge:
 - latch req[63:6] as the line index modulo MEM_LINES; req[5:0] is ignored;
 - latch reqtag;
 - pulse reqack high for exactly one cycle.
REQ-006 After reqack, the next state SHALL be chosen by the latched tag:
 - READ with type MEMORY: go to WAIT, loading the latency counter with LATENCY.
 - WRITE with type MEMORY: go to WDATA.
 - any other type: ack, discard, and return to IDLE.
REQ-007 In WDATA, the block SHALL capture req as beat k (k=0..7) on every cycle with reqcyc=1:
 - store it at byte offset 8k of the latched line;
 - ignore cycles with reqcyc=0;
 - after beat 7, return to IDLE;
 - generate no response for a write.
REQ-008 In WAIT, the counter SHALL decrement each cycle and enter RESP when it reaches 0; the first beat appears exactly LATENCY+1 cycles after the reqack cycle.
REQ-009 In RESP, the block SHALL drive the beats in order:
 - respcyc=1, resp = bytes 8k..8k+7 of the line (little-endian), resptag = latched tag;
 - advance k only on cycles with respcyc and respack both high;
 - hold resp and k stable while respack=0.
REQ-010 After beat 7 is accepted, respcyc SHALL drop to 0 at the next edge and the state SHALL return to IDLE.
REQ-011 reqack SHALL NOT be asserted outside IDLE; reqcyc seen in WAIT or RESP is held off until IDLE, with no back-to-back overlap.
REQ-012 A write followed by a read to the same line SHALL return the written data.
REQ-013 The beat counter SHALL be 3 bits and the latency counter ceil(log2(LATENCY+1)) bits; neither wraps except k after beat 7.

Reset
REQ-014 While reset=1, the block SHALL force:
 - state=IDLE, reqack=0, respcyc=0;
 - resp=0, resptag=0;
 - beat and latency counters = 0.
REQ-015 Reset SHALL NOT clear the memory array; its contents are undefined until written.
REQ-016 Reset asserted mid-WDATA or mid-RESP SHALL abort the transaction immediately:
 - no further beats and no reqack are produced;
 - beats already written remain in memory.
REQ-017 After reset deasserts, the first request is accepted per REQ-005.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
 - Write line 0x1000 with beats 0x11..0x88, then read 0x1000 with respack tied to respcyc -> 8 consecutive beats 0x11..0x88, first beat LATENCY+1=5 cycles after reqack.
 - Read 0x1038 -> reqack once, data identical to read of 0x1000 (offset bits ignored).
 - Read with respack low on beats 2 and 5 for 3 cycles each -> resp held constant, 8 beats total, respcyc high 14 cycles.
 - reqcyc held high through a read response -> second reqack only in the cycle after returning to IDLE.
 - Reset during beat 3 of RESP -> respcyc=0 asynchronously, state IDLE, next read completes normally.
 - Address MEM_LINES*64 + 0x40 -> aliases line 1.

Source files
------------

// File: rtl/sysbus_mem_responder.sv
// Line-addressed memory target: accepts 64-byte line reads/writes on the sysbus request channel.
// Latency: first read beat LATENCY+1 cycles after the reqack cycle; writes absorb 8 beats, no response.
// Backpressure: no reqack outside IDLE (requests wait); respack=0 freezes the presented beat.
module sysbus_mem_responder #(
    parameter int MEM_LINES = 256,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqcyc,
    input  logic [63:0] req,
    input  logic [12:0] reqtag,
    output logic        reqack,
    output logic        respcyc,
    output logic [63:0] resp,
    output logic [12:0] resptag,
    input  logic        respack
);

    localparam int         LINE_W      = $clog2(MEM_LINES);
    localparam int         CNT_W       = $clog2(LATENCY + 1);
    localparam logic [3:0] TYPE_MEMORY = 4'b0001;

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        WAIT,
        RESP
    } state_t;

    state_t             state;
    logic [LINE_W-1:0]  line;
    logic [2:0]         beat;
    logic [CNT_W-1:0]   lat_cnt;

    // One 64-bit word per beat; a line occupies 8 consecutive words.
    logic [63:0] mem [0:MEM_LINES*8-1];

    // Control FSM. The latched tag lives in resptag so it is presented as-is with every beat.
    // reqack is raised while still in IDLE; the dispatch on the latched tag happens in the
    // following cycle, which keeps reqack strictly inside IDLE and stops a still-high reqcyc
    // (the initiator only drops it after seeing reqack) from being taken as a new request
    // or as write beat 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            reqack  <= 1'b0;
            respcyc <= 1'b0;
            resp    <= '0;
            resptag <= '0;
            line    <= '0;
            beat    <= '0;
            lat_cnt <= '0;
        end else begin
            reqack <= 1'b0;
            case (state)
                IDLE: begin
                    if (reqack) begin
                        if (resptag[11:8] == TYPE_MEMORY) begin
                            if (resptag[12]) begin
                                state   <= WAIT;
                                lat_cnt <= CNT_W'(LATENCY);
                            end else begin
                                state <= WDATA;
                                beat  <= '0;
                            end
                        end
                    end else if (reqcyc) begin
                        line    <= req[6 +: LINE_W];
                        resptag <= reqtag;
                        reqack  <= 1'b1;
                    end
                end

                WDATA: begin
                    if (reqcyc) begin
                        beat <= beat + 3'd1;
                        if (beat == 3'd7) begin
                            state <= IDLE;
                        end
                    end
                end

                WAIT: begin
                    // Counter hits 0 on the same edge that moves to RESP.
                    lat_cnt <= lat_cnt - CNT_W'(1);
                    if (lat_cnt == CNT_W'(1)) begin
                        state   <= RESP;
                        beat    <= '0;
                        respcyc <= 1'b1;
                        resp    <= mem[{line, 3'd0}];
                    end
                end

                RESP: begin
                    if (respcyc && respack) begin
                        if (beat == 3'd7) begin
                            state   <= IDLE;
                            respcyc <= 1'b0;
                            beat    <= '0;
                        end else begin
                            beat <= beat + 3'd1;
                            resp <= mem[{line, beat + 3'd1}];
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write port: store each valid write beat; reset leaves the array untouched.
    always_ff @(posedge clk) begin
        if (state == WDATA && reqcyc) begin
            mem[{line, beat}] <= req;
        end
    end

endmodule
